// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM encoding, default
// parameter values and the counter-width helper.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_STRETCH = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } seq_state_e;

  localparam int RST_SEQ_NUM_RST        = 3;
  localparam int RST_SEQ_NUM_LOCK       = 2;
  localparam int RST_SEQ_STRETCH_CYCLES = 16;
  localparam int RST_SEQ_STAGE_GAP      = 8;
  localparam int RST_SEQ_LOCK_FILTER    = 4;
  localparam int RST_SEQ_LOSS_CNT_W     = 8;

  // Width of a counter that must hold 0..maxval-1, never narrower than one bit.
  function automatic int cnt_width(input int maxval);
    return (maxval > 1) ? $clog2(maxval) : 1;
  endfunction

endpackage

// File: rtl/rst_seq_sync.sv
// Two-flop synchroniser for one asynchronous lock indication.
module rst_seq_sync (
  input  logic wb_clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_p0;
  logic sync_p1;

  always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      meta_p0 <= d_i;
      sync_p1 <= meta_p0;
    end
  end

  assign q_o = sync_p1;

endmodule

// File: rtl/rst_sequencer.sv
// Staged reset release gated on PLL/DCM lock, with filtered lock-loss
// detection, software reset and a saturating lock-loss counter.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_RST        = RST_SEQ_NUM_RST,
  parameter int NUM_LOCK       = RST_SEQ_NUM_LOCK,
  parameter int STRETCH_CYCLES = RST_SEQ_STRETCH_CYCLES,
  parameter int STAGE_GAP      = RST_SEQ_STAGE_GAP,
  parameter int LOCK_FILTER    = RST_SEQ_LOCK_FILTER
) (
  input  logic                          wb_clk_i,
  input  logic                          rst_n_i,
  input  logic [NUM_LOCK-1:0]           lock_i,
  input  logic                          sw_rst_i,
  output logic [NUM_RST-1:0]            rst_o,
  output logic                          seq_done_o,
  output logic                          lock_loss_o,
  output logic [RST_SEQ_LOSS_CNT_W-1:0] lock_loss_cnt_o
);

  localparam int SCW = cnt_width(STRETCH_CYCLES);
  localparam int GCW = cnt_width(STAGE_GAP);
  localparam int FCW = cnt_width(LOCK_FILTER);
  localparam int IW  = cnt_width(NUM_RST);
  localparam int LW  = RST_SEQ_LOSS_CNT_W;

  function automatic logic [LW-1:0] sat_inc(input logic [LW-1:0] v);
    return (v == {LW{1'b1}}) ? v : v + LW'(1);
  endfunction

  logic [NUM_LOCK-1:0] lock_s;
  logic                all_locked;

  for (genvar i = 0; i < NUM_LOCK; i++) begin : g_sync
    rst_seq_sync u_sync (
      .wb_clk_i (wb_clk_i),
      .rst_n_i  (rst_n_i),
      .d_i      (lock_i[i]),
      .q_o      (lock_s[i])
    );
  end

  assign all_locked = &lock_s;

  seq_state_e      state_q, state_d;
  logic [SCW-1:0]  scnt_q, scnt_d;
  logic [GCW-1:0]  gcnt_q, gcnt_d;
  logic [FCW-1:0]  fcnt_q, fcnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [NUM_RST-1:0] rst_q, rst_d;
  logic            done_q, done_d;
  logic            loss_q, loss_d;
  logic [LW-1:0]   cnt_q, cnt_d;
  logic            lost;

  always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_HOLD;
      scnt_q  <= '0;
      gcnt_q  <= '0;
      fcnt_q  <= '0;
      idx_q   <= '0;
      rst_q   <= '1;
      done_q  <= 1'b0;
      loss_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      gcnt_q  <= gcnt_d;
      fcnt_q  <= fcnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
      loss_q  <= loss_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    gcnt_d  = gcnt_q;
    fcnt_d  = fcnt_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    done_d  = done_q;
    loss_d  = 1'b0;
    cnt_d   = cnt_q;
    lost    = 1'b0;

    // Lock-loss filter only runs once releases have begun.
    if (state_q == ST_RELEASE || state_q == ST_RUN) begin
      if (all_locked) begin
        fcnt_d = '0;
      end else if (fcnt_q == FCW'(LOCK_FILTER - 1)) begin
        lost = 1'b1;
      end else begin
        fcnt_d = fcnt_q + FCW'(1);
      end
    end

    if (sw_rst_i || lost) begin
      state_d = ST_HOLD;
      scnt_d  = '0;
      gcnt_d  = '0;
      fcnt_d  = '0;
      idx_d   = '0;
      rst_d   = '1;
      done_d  = 1'b0;
      // A simultaneous software reset swallows the loss event.
      if (!sw_rst_i) begin
        loss_d = 1'b1;
        cnt_d  = sat_inc(cnt_q);
      end
    end else begin
      unique case (state_q)
        ST_HOLD: begin
          scnt_d = '0;
          if (all_locked) state_d = ST_STRETCH;
        end
        ST_STRETCH: begin
          if (!all_locked) begin
            state_d = ST_HOLD;
            scnt_d  = '0;
          end else if (scnt_q == SCW'(STRETCH_CYCLES - 1)) begin
            rst_d[0] = 1'b0;
            scnt_d   = '0;
            gcnt_d   = '0;
            fcnt_d   = '0;
            idx_d    = IW'(1);
            if (NUM_RST == 1) begin
              done_d  = 1'b1;
              state_d = ST_RUN;
            end else begin
              state_d = ST_RELEASE;
            end
          end else begin
            scnt_d = scnt_q + SCW'(1);
          end
        end
        ST_RELEASE: begin
          if (gcnt_q == GCW'(STAGE_GAP - 1)) begin
            gcnt_d       = '0;
            rst_d[idx_q] = 1'b0;
            if (idx_q == IW'(NUM_RST - 1)) begin
              done_d  = 1'b1;
              state_d = ST_RUN;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else begin
            gcnt_d = gcnt_q + GCW'(1);
          end
        end
        ST_RUN: begin
          state_d = ST_RUN;
        end
        default: begin
          state_d = ST_HOLD;
          rst_d   = '1;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  assign rst_o           = rst_q;
  assign seq_done_o      = done_q;
  assign lock_loss_o     = loss_q;
  assign lock_loss_cnt_o = cnt_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Randomised and directed bench for rst_sequencer against a timeline-based
// reference model (release times computed from elapsed cycles).
module tb_rst_sequencer;

  localparam int NR = 3;
  localparam int NL = 2;
  localparam int S  = 16;
  localparam int G  = 8;
  localparam int LF = 4;

  logic          wb_clk_i;
  logic          rst_n_i;
  logic [NL-1:0] lock_i;
  logic          sw_rst_i;
  logic [NR-1:0] rst_o;
  logic          seq_done_o;
  logic          lock_loss_o;
  logic [7:0]    lock_loss_cnt_o;

  rst_sequencer #(
    .NUM_RST(NR), .NUM_LOCK(NL), .STRETCH_CYCLES(S), .STAGE_GAP(G), .LOCK_FILTER(LF)
  ) dut (
    .wb_clk_i        (wb_clk_i),
    .rst_n_i         (rst_n_i),
    .lock_i          (lock_i),
    .sw_rst_i        (sw_rst_i),
    .rst_o           (rst_o),
    .seq_done_o      (seq_done_o),
    .lock_loss_o     (lock_loss_o),
    .lock_loss_cnt_o (lock_loss_cnt_o)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: the sequence is either idle (counting consecutive locked
  // cycles) or running, in which case rst_o[k] is free once k*G cycles have
  // elapsed since the first release.
  logic [NL-1:0] m_l1, m_l2;
  bit            m_seq;
  int            m_arm, m_trel, m_low, m_cnt;
  bit            m_loss;

  task automatic m_reset();
    m_l1 = '0; m_l2 = '0;
    m_seq = 0; m_arm = 0; m_trel = 0; m_low = 0; m_cnt = 0; m_loss = 0;
  endtask

  task automatic m_edge();
    bit al;
    al = &m_l2;
    m_l2 = m_l1;
    m_l1 = lock_i;
    m_loss = 0;
    if (m_seq) m_low = al ? 0 : m_low + 1;
    if (sw_rst_i) begin
      m_seq = 0; m_arm = 0; m_low = 0;
    end else if (m_seq && m_low >= LF) begin
      m_seq = 0; m_arm = 0; m_low = 0; m_loss = 1;
      if (m_cnt < 255) m_cnt++;
    end else if (m_seq) begin
      m_trel++;
    end else if (al) begin
      m_arm++;
      if (m_arm == S + 1) begin
        m_seq = 1; m_trel = 0; m_low = 0;
      end
    end else begin
      m_arm = 0;
    end
  endtask

  function automatic logic [NR-1:0] exp_rst();
    logic [NR-1:0] r;
    for (int k = 0; k < NR; k++) r[k] = !(m_seq && m_trel >= k * G);
    return r;
  endfunction

  function automatic logic exp_done();
    return m_seq && (m_trel >= (NR - 1) * G);
  endfunction

  task automatic step();
    @(posedge wb_clk_i);
    if (!rst_n_i) m_reset(); else m_edge();
    #1;
    chk("rst_o", 32'(rst_o), 32'(exp_rst()));
    chk("seq_done", 32'(seq_done_o), 32'(exp_done()));
    chk("lock_loss", 32'(lock_loss_o), 32'(m_loss));
    chk("loss_cnt", 32'(lock_loss_cnt_o), 32'(m_cnt));
  endtask

  task automatic run_until_done(input int budget);
    int n;
    n = 0;
    while (!seq_done_o && n < budget) begin
      step();
      n++;
    end
    chk("done_wait", 32'(seq_done_o), 32'd1);
  endtask

  task automatic release_timing(input string tag);
    int f0, f1, f2, fd;
    f0 = -1; f1 = -1; f2 = -1; fd = -1;
    rst_n_i = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step();
      if (f0 < 0 && !rst_o[0]) f0 = c;
      if (f1 < 0 && !rst_o[1]) f1 = c;
      if (f2 < 0 && !rst_o[2]) f2 = c;
      if (fd < 0 && seq_done_o) fd = c;
    end
    chk({tag, "_rel0"}, 32'(f0), 32'd18);
    chk({tag, "_rel1"}, 32'(f1), 32'd26);
    chk({tag, "_rel2"}, 32'(f2), 32'd34);
    chk({tag, "_done"}, 32'(fd), 32'd34);
  endtask

  initial begin
    int pulses, n;
    m_reset();
    rst_n_i  = 1'b0;
    lock_i   = 2'b11;
    sw_rst_i = 1'b0;
    repeat (3) step();
    chk("reset_rst_o", 32'(rst_o), 32'h7);
    chk("reset_done", 32'(seq_done_o), 32'd0);

    // Locks already present when reset releases.
    release_timing("boot");

    // Short drop in RUN is filtered; a long one is a loss.
    lock_i = 2'b10; repeat (3) step();
    lock_i = 2'b11; repeat (6) step();
    chk("short_drop_done", 32'(seq_done_o), 32'd1);
    chk("short_drop_cnt", 32'(lock_loss_cnt_o), 32'd0);
    lock_i = 2'b10; pulses = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      pulses += int'(lock_loss_o);
    end
    chk("loss_pulses", 32'(pulses), 32'd1);
    chk("loss_cnt1", 32'(lock_loss_cnt_o), 32'd1);
    chk("loss_rst_o", 32'(rst_o), 32'h7);
    lock_i = 2'b11;
    run_until_done(60);

    // Software reset in RUN.
    sw_rst_i = 1'b1; step(); sw_rst_i = 1'b0;
    chk("sw_rst_o", 32'(rst_o), 32'h7);
    chk("sw_cnt", 32'(lock_loss_cnt_o), 32'd1);
    chk("sw_pulse", 32'(lock_loss_o), 32'd0);
    run_until_done(60);

    // Software reset lands on the very cycle the loss would be detected.
    lock_i = 2'b01; n = 0;
    while (!(m_seq && m_low == LF - 1) && n < 20) begin
      step();
      n++;
    end
    chk("coinc_wait", 32'(n < 20), 32'd1);
    sw_rst_i = 1'b1; step(); sw_rst_i = 1'b0;
    chk("coinc_pulse", 32'(lock_loss_o), 32'd0);
    chk("coinc_cnt", 32'(lock_loss_cnt_o), 32'd1);
    chk("coinc_rst_o", 32'(rst_o), 32'h7);

    // Asynchronous reset between the first and second release.
    lock_i = 2'b11; n = 0;
    while (rst_o[0] && n < 60) begin
      step();
      n++;
    end
    repeat (3) step();
    chk("arst_mid", 32'(rst_o), 32'h6);
    #2 rst_n_i = 1'b0;
    #1 m_reset();
    chk("arst_rst_o", 32'(rst_o), 32'h7);
    chk("arst_done", 32'(seq_done_o), 32'd0);
    chk("arst_pulse", 32'(lock_loss_o), 32'd0);
    chk("arst_cnt", 32'(lock_loss_cnt_o), 32'd0);
    repeat (2) step();
    release_timing("rearm");

    // Randomised lock activity and software resets.
    for (int s = 0; s < 200; s++) begin
      int kind;
      int len;
      kind = $urandom_range(0, 9);
      if (kind <= 4) begin
        lock_i = 2'b11;
        len = $urandom_range(1, 40);
        repeat (len) step();
      end else if (kind <= 7) begin
        lock_i = 2'($urandom_range(0, 2));
        len = $urandom_range(1, 7);
        repeat (len) step();
      end else if (kind == 8) begin
        lock_i = 2'($urandom_range(0, 3));
        sw_rst_i = 1'b1; step(); sw_rst_i = 1'b0;
      end else begin
        lock_i = 2'($urandom_range(0, 2));
        len = $urandom_range(3, 6);
        repeat (len - 1) step();
        sw_rst_i = 1'b1; step(); sw_rst_i = 1'b0;
      end
    end

    // 256 forced losses from a cleared counter.
    #2 rst_n_i = 1'b0;
    #1 m_reset();
    repeat (2) step();
    rst_n_i = 1'b1;
    for (int i = 0; i < 256; i++) begin
      lock_i = 2'b11; n = 0;
      while (rst_o[0] && n < 40) begin
        step();
        n++;
      end
      lock_i = 2'b00;
      repeat (LF + 4) step();
    end
    chk("cnt_sat", 32'(lock_loss_cnt_o), 32'd255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/rst_sequencer.md
RST_SEQUENCER -- requirements
Module: rst_sequencer

Interface
REQ-001 SHALL have parameter NUM_RST, default 3, giving the number of sequenced reset outputs (1..8).
REQ-002 SHALL have parameter NUM_LOCK, default 2, giving the number of PLL/DCM lock inputs (1..4).
REQ-003 SHALL have parameter STRETCH_CYCLES, default 16, giving the number of stable all-locked cycles required before the first release (1..65535).
REQ-004 SHALL have parameter STAGE_GAP, default 8, giving the cycles between successive releases (1..255).
REQ-005 SHALL have parameter LOCK_FILTER, default 4, giving the consecutive not-locked cycles that count as a lock loss (1..255).
REQ-006 SHALL have ports wb_clk_i, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-007 SHALL have ports rst_n_i, input, 1 bit: reset, asynchronous and active-low.
REQ-008 SHALL have lock_i, input, NUM_LOCK bits: asynchronous lock indications, active high.
REQ-009 SHALL have sw_rst_i, input, 1 bit: synchronous software reset request, sampled each cycle.
REQ-010 SHALL have rst_o, output, NUM_RST bits: active-high resets; bit 0 is released first.
REQ-011 SHALL have seq_done_o, output, 1 bit: high while all rst_o bits are released.
REQ-012 SHALL have lock_loss_o, output, 1 bit: one-cycle pulse on each detected lock loss.
REQ-013 SHALL have lock_loss_cnt_o, output, 8 bits: count of lock losses, saturating at 255.

Function
REQ-014 SHALL pass each lock_i bit through a 2-flop synchroniser; all_locked is the AND of the synchronised bits.
REQ-015 SHALL implement the FSM states HOLD, STRETCH, RELEASE and RUN, all registered.
REQ-016 HOLD SHALL assert all rst_o and move to STRETCH in the first cycle all_locked=1.
REQ-017 STRETCH SHALL count all_locked=1 cycles; any all_locked=0 cycle returns to HOLD and clears the counter.
REQ-018 The rst_o[0] bit SHALL deassert exactly STRETCH_CYCLES cycles after the first all_locked=1 cycle; FSM enters RELEASE.
REQ-019 In RELEASE, rst_o[k] SHALL deassert exactly STAGE_GAP cycles after rst_o[k-1], for k=1..NUM_RST-1.
REQ-020 seq_done_o SHALL rise in the same cycle rst_o[NUM_RST-1] deasserts; FSM enters RUN; with NUM_RST=1 this coincides with the rst_o[0] release.
REQ-021 In RELEASE or RUN, LOCK_FILTER consecutive all_locked=0 cycles SHALL be a lock loss: next cycle all rst_o=1, seq_done_o=0, lock_loss_o=1 for one cycle, counter +1 (saturating), FSM to HOLD.
REQ-022 An all_locked=0 run shorter than LOCK_FILTER cycles in RELEASE/RUN SHALL be ignored; the filter counter clears on any all_locked=1 cycle.
REQ-023 sw_rst_i=1 in any state SHALL, next cycle, assert all rst_o, clear seq_done_o and go to HOLD, without a lock_loss_o pulse or count.
REQ-024 sw_rst_i and lock-loss detection in the same cycle: sw_rst_i SHALL win, and the loss is neither pulsed nor counted.
REQ-025 A release SHALL occur only when no release in the same cycle is pending; rst_o bits, once re-asserted, are released only by a fresh HOLD→STRETCH→RELEASE pass.
REQ-026 rst_o SHALL be driven directly from flops (no combinational output path).

Reset
REQ-027 rst_n_i low SHALL immediately (asynchronously) set rst_o all-ones, seq_done_o=0, lock_loss_o=0, lock_loss_cnt_o=0, synchronisers=0, counters=0 and FSM=HOLD.
REQ-028 Deassertion of rst_n_i SHALL take effect synchronously; the first possible release is no earlier than 2+STRETCH_CYCLES cycles later.
REQ-029 rst_n_i low mid-sequence or in RUN SHALL abort it with no lock_loss_o pulse.

Structure
REQ-030 State encodings and default parameter values SHALL live in the shared package rst_seq_pkg.
REQ-031 The 2-flop synchroniser SHALL be a sub-module rst_seq_sync, instantiated NUM_LOCK times.
REQ-032 Counter widths SHALL be derived from the parameters (clog2), and the RTL SHALL be 120-400 lines.

Verification
REQ-033 Defaults; lock_i=2'b11 at cycle 0 after reset release -> rst_o[0] falls at cycle 18, rst_o[1] at 26, rst_o[2] at 34; seq_done_o rises at 34.
REQ-034 lock_i[1] dropped for 2 cycles during STRETCH -> counter restarts; the release is delayed by the drop plus 16 cycles.
REQ-035 In RUN, lock_i[0] low for 3 cycles -> no effect; low for 4+ cycles -> rst_o=3'b111, one lock_loss_o pulse, lock_loss_cnt_o=1, then a re-sequence after re-lock.
REQ-036 sw_rst_i pulse in RUN -> rst_o=3'b111 next cycle, lock_loss_cnt_o unchanged, full sequence repeats.
REQ-037 256 forced lock losses -> lock_loss_cnt_o stays at 255.
REQ-038 rst_n_i asserted between the rst_o[0] and rst_o[1] releases -> all outputs reset asynchronously; sequence restarts from HOLD.
